mask_centroid: RTL
==================

# mask_centroid

Downstream of the pixel threshold stage: consumes the registered 1-bit mask with its pixel coordinates and accumulates x-sum, y-sum and count of set-mask pixels over a frame. At frame end it snapshots the totals and runs a multi-cycle serial division to produce the integer centroid (x, y) of the masked region. It then presents the centroid with a one-cycle valid pulse for the overlay and crosshair logic. The next frame accumulates while the division runs.

## Interface
- H_RES, 1280, active pixels per line; hcount range 0..H_RES-1
- V_RES, 720, active lines per frame; vcount range 0..V_RES-1
- MIN_COUNT, 1, minimum masked-pixel count for a frame to produce a result
- clk  input  1  pixel clock; all logic on rising edge
- rst  input  1  reset; asynchronous assert, active-low (0 = reset)
- hcount  input  11  x coordinate of the current mask sample
- vcount  input  10  y coordinate of the current mask sample
- data_valid  input  1  mask, hcount and vcount are a valid active-area sample
- mask  input  1  threshold result, already aligned with hcount/vcount by upstream
- frame_done  input  1  single-cycle pulse marking the end of the active frame
- x_out  output  11  centroid x, floor(x_sum/count)
- y_out  output  10  centroid y, floor(y_sum/count)
- out_valid  output  1  one-cycle pulse when x_out/y_out update
- busy  output  1  high while the division is in progress

## Operation
- Accumulators: x_acc 32b, y_acc 32b, cnt_acc 20b. Worst case is a full frame: 921600 pixels, x_sum < 2^31, y_sum < 2^30.
- Accumulation runs in every state. If data_valid && mask, then x_acc += hcount, y_acc += vcount and cnt_acc += 1.
- FSM states: IDLE, DIVIDE, DONE.
- IDLE, frame_done=1:
  - Snapshot the totals into the divider, including a data_valid && mask sample in the same cycle.
  - Clear the accumulators.
  - If the snapshot count ≥ MIN_COUNT, go to DIVIDE. Otherwise stay in IDLE: no out_valid, outputs hold.
- DIVIDE: two restoring dividers run in parallel (x_sum/count, y_sum/count), 1 quotient bit per cycle, 32 iterations. Then go to DONE.
- DONE: register the quotients into x_out/y_out, pulse out_valid, return to IDLE.
- frame_done while busy: that frame is discarded. Accumulators clear, the in-flight division is unaffected, and no extra out_valid is produced.
- Quotient truncation to 11/10 bits is exact because the centroid always lies inside the coordinate range.
- Samples with data_valid=0 are ignored regardless of mask.

## Timing
- Reset values: x_out=0, y_out=0, out_valid=0, busy=0, FSM=IDLE, all accumulators and divider registers 0.
- Reset asserted mid-division aborts it immediately. No out_valid follows reset release.
- frame_done sampled at edge N:
  - busy high from edge N through edge N+32.
  - x_out/y_out update and out_valid is high for the cycle after edge N+33.
  - Fixed latency is 33 cycles.
- out_valid is never high for more than one consecutive cycle.
- x_out/y_out change only on an out_valid cycle.
- Accumulation has zero latency: a sample presented at edge K is in the totals at edge K+1.

## Configuration
- CENTROID_BBOX_EN defined:
  - Adds outputs x_min, x_max (11b) and y_min, y_max (10b): the bounding box of masked pixels in the frame.
  - They are tracked alongside the accumulators, snapshotted on frame_done, and updated in the same cycle as x_out/y_out.
  - Reset value is 0. The internal trackers reinitialise to min=all-ones, max=0 at each frame_done.
- Not defined: no bounding-box ports or logic. All other behaviour is identical.

## Test plan
- Single pixel: mask at (100,50) only, then frame_done → x_out=100, y_out=50, out_valid exactly 33 cycles after frame_done, busy high 33 cycles. With BBOX, min=max=(100,50).
- 10×10 square covering x 200..209, y 300..309 → x_out=204, y_out=304 (floor of 204.5 / 304.5).
- Full 1280×720 frame with mask=1 → cnt 921600, x_out=639, y_out=359. No accumulator overflow.
- Empty frame, or count < MIN_COUNT → out_valid stays 0, x_out/y_out retain previous values, busy stays 0.
- frame_done during DIVIDE:
  - The pending result still emits once with the first frame's values.
  - Pixels from the second frame are discarded.
  - A third frame computes correctly.
- Reset asserted at cycle 10 of DIVIDE:
  - All outputs go to 0 asynchronously.
  - No out_valid after release.
  - A following frame with a pixel at (5,7) yields (5,7).

Source files
------------

// File: rtl/mask_centroid.sv
// mask_centroid: accumulates x/y sums and count of masked pixels per frame,
// then serially divides at frame end to give the integer centroid.
//
// Ports:
//   clk        : pixel clock, rising edge
//   rst        : async reset, active-low
//   hcount     : x of current mask sample (0..H_RES-1)
//   vcount     : y of current mask sample (0..V_RES-1)
//   data_valid : sample is in the active area
//   mask       : threshold result aligned to hcount/vcount
//   frame_done : one-cycle end-of-frame pulse
//   x_out      : floor(x_sum/count)
//   y_out      : floor(y_sum/count)
//   out_valid  : one-cycle pulse when x_out/y_out update
//   busy       : division in progress
//
// Optional: define CENTROID_BBOX_EN to add x_min/x_max/y_min/y_max,
// the bounding box of masked pixels, updated together with x_out/y_out.
`timescale 1ns/1ps

module mask_centroid #(
  parameter int H_RES     = 1280,
  parameter int V_RES     = 720,
  parameter int MIN_COUNT = 1,
  localparam int XW = $clog2(H_RES),
  localparam int YW = $clog2(V_RES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] hcount,
  input  logic [YW-1:0] vcount,
  input  logic          data_valid,
  input  logic          mask,
  input  logic          frame_done,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic          out_valid,
  output logic          busy
`ifdef CENTROID_BBOX_EN
  ,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max
`endif
);

  localparam logic [19:0] MIN_C = 20'(MIN_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    DONE
  } state_t;

  state_t st_q, st_d;

  logic [31:0] x_acc_q, y_acc_q;
  logic [19:0] cnt_acc_q;
  logic [31:0] x_sum_d, y_sum_d;
  logic [19:0] cnt_sum_d;
  logic        hit;

  logic [31:0] qx_q, qy_q;
  logic [19:0] rx_q, ry_q;
  logic [19:0] dv_q;
  logic [4:0]  it_q;

  logic [20:0] trx, try_;
  logic        gex, gey;
  logic [19:0] rx_d, ry_d;

  logic [XW-1:0] x_out_q;
  logic [YW-1:0] y_out_q;
  logic          ov_q;

  logic load, step;

  // Running totals including this cycle's sample, so a sample that
  // coincides with frame_done still lands in the snapshot.
  assign hit       = data_valid & mask;
  assign x_sum_d   = x_acc_q
                   + (hit ? {{(32-XW){1'b0}}, hcount} : 32'd0);
  assign y_sum_d   = y_acc_q
                   + (hit ? {{(32-YW){1'b0}}, vcount} : 32'd0);
  assign cnt_sum_d = cnt_acc_q + (hit ? 20'd1 : 20'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_acc_q   <= '0;
      y_acc_q   <= '0;
      cnt_acc_q <= '0;
    end else if (frame_done) begin
      x_acc_q   <= '0;
      y_acc_q   <= '0;
      cnt_acc_q <= '0;
    end else begin
      x_acc_q   <= x_sum_d;
      y_acc_q   <= y_sum_d;
      cnt_acc_q <= cnt_sum_d;
    end
  end

  always_comb begin
    st_d = st_q;
    load = 1'b0;
    step = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (frame_done && cnt_sum_d >= MIN_C) begin
          st_d = DIVIDE;
          load = 1'b1;
        end
      end
      DIVIDE: begin
        step = 1'b1;
        if (it_q == 5'd31) st_d = DONE;
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= IDLE;
    else      st_q <= st_d;
  end

  // Restoring divide step: shift the next dividend bit into the
  // remainder, subtract when it fits. Remainder stays below the
  // divisor, so 20 bits suffice once the trial bit is consumed.
  assign trx  = {rx_q, qx_q[31]};
  assign try_ = {ry_q, qy_q[31]};
  assign gex  = trx >= {1'b0, dv_q};
  assign gey  = try_ >= {1'b0, dv_q};
  assign rx_d = gex ? trx[19:0] - dv_q : trx[19:0];
  assign ry_d = gey ? try_[19:0] - dv_q : try_[19:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qx_q <= '0;
      qy_q <= '0;
      rx_q <= '0;
      ry_q <= '0;
      dv_q <= '0;
      it_q <= '0;
    end else if (load) begin
      qx_q <= x_sum_d;
      qy_q <= y_sum_d;
      rx_q <= '0;
      ry_q <= '0;
      dv_q <= cnt_sum_d;
      it_q <= '0;
    end else if (step) begin
      qx_q <= {qx_q[30:0], gex};
      qy_q <= {qy_q[30:0], gey};
      rx_q <= rx_d;
      ry_q <= ry_d;
      it_q <= it_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_out_q <= '0;
      y_out_q <= '0;
      ov_q    <= 1'b0;
    end else begin
      ov_q <= (st_q == DONE);
      if (st_q == DONE) begin
        x_out_q <= qx_q[XW-1:0];
        y_out_q <= qy_q[YW-1:0];
      end
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign out_valid = ov_q;
  assign busy      = (st_q != IDLE);

`ifdef CENTROID_BBOX_EN
  logic [XW-1:0] xmn_q, xmx_q, xmn_d, xmx_d;
  logic [YW-1:0] ymn_q, ymx_q, ymn_d, ymx_d;
  logic [XW-1:0] sxmn_q, sxmx_q, x_min_q, x_max_q;
  logic [YW-1:0] symn_q, symx_q, y_min_q, y_max_q;

  always_comb begin
    xmn_d = xmn_q;
    xmx_d = xmx_q;
    ymn_d = ymn_q;
    ymx_d = ymx_q;
    if (hit) begin
      if (hcount < xmn_q) xmn_d = hcount;
      if (hcount > xmx_q) xmx_d = hcount;
      if (vcount < ymn_q) ymn_d = vcount;
      if (vcount > ymx_q) ymx_d = vcount;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xmn_q <= '1;
      xmx_q <= '0;
      ymn_q <= '1;
      ymx_q <= '0;
    end else if (frame_done) begin
      xmn_q <= '1;
      xmx_q <= '0;
      ymn_q <= '1;
      ymx_q <= '0;
    end else begin
      xmn_q <= xmn_d;
      xmx_q <= xmx_d;
      ymn_q <= ymn_d;
      ymx_q <= ymx_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sxmn_q  <= '0;
      sxmx_q  <= '0;
      symn_q  <= '0;
      symx_q  <= '0;
      x_min_q <= '0;
      x_max_q <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
    end else begin
      if (load) begin
        sxmn_q <= xmn_d;
        sxmx_q <= xmx_d;
        symn_q <= ymn_d;
        symx_q <= ymx_d;
      end
      if (st_q == DONE) begin
        x_min_q <= sxmn_q;
        x_max_q <= sxmx_q;
        y_min_q <= symn_q;
        y_max_q <= symx_q;
      end
    end
  end

  assign x_min = x_min_q;
  assign x_max = x_max_q;
  assign y_min = y_min_q;
  assign y_max = y_max_q;
`endif

endmodule
